// File: rtl/dmem_ctrl_pkg.sv
// Shared types and constants for the data-memory access controller.
//   state_t : sequencing FSM states
//   owner_t : which requester owns the transaction in flight
//   F3_*    : RISC-V funct3 encodings for loads/stores
package dmem_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StMerge  = 2'd2,
    StResp   = 2'd3
  } state_t;

  typedef enum logic {
    OwnC = 1'b0,
    OwnD = 1'b1
  } owner_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/dmem_access_ctrl_align.sv
// Combinational load/store alignment helper.
//   we_i/funct3_i/addr_i : access being checked (legality)
//   rd_word_i            : word read at addr (bytes addr..addr+3), used for load extension
//   old_word_i           : word captured for read-modify-write
//   wdata_i              : right-aligned store data
//   load_data_o          : sign/zero-extended load result
//   merged_o             : old word with the low byte/half replaced by store data
//   legal_o              : access is legal (size/alignment/top-of-memory rules)
module lsu_align
  import dmem_ctrl_pkg::*;
#(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned AddrWidth = 17
) (
  input  logic                 we_i,
  input  logic [2:0]           funct3_i,
  input  logic [AddrWidth-1:0] addr_i,
  input  logic [DataWidth-1:0] rd_word_i,
  input  logic [DataWidth-1:0] old_word_i,
  input  logic [DataWidth-1:0] wdata_i,
  output logic [DataWidth-1:0] load_data_o,
  output logic [DataWidth-1:0] merged_o,
  output logic                 legal_o
);

  // Highest byte address whose 4-byte window does not wrap.
  localparam logic [AddrWidth-1:0] LastWordAddr = ~AddrWidth'(3);

  always_comb begin
    legal_o = 1'b1;
    if (funct3_i[1:0] == 2'b11) legal_o = 1'b0;
    if (!we_i && (funct3_i == 3'b110 || funct3_i == 3'b111)) legal_o = 1'b0;
    if (we_i && funct3_i[2]) legal_o = 1'b0;
    if (funct3_i[1:0] == 2'b01 && addr_i[0]) legal_o = 1'b0;
    if (funct3_i[1:0] == 2'b10 && addr_i[1:0] != 2'b00) legal_o = 1'b0;
    // SB/SH rewrite a whole word, which would wrap past the top of memory.
    if (we_i && !funct3_i[1] && addr_i > LastWordAddr) legal_o = 1'b0;
  end

  always_comb begin
    load_data_o = '0;
    case (funct3_i)
      F3_B:    load_data_o = {{(DataWidth-8){rd_word_i[7]}}, rd_word_i[7:0]};
      F3_H:    load_data_o = {{(DataWidth-16){rd_word_i[15]}}, rd_word_i[15:0]};
      F3_W:    load_data_o = rd_word_i;
      F3_BU:   load_data_o = {{(DataWidth-8){1'b0}}, rd_word_i[7:0]};
      F3_HU:   load_data_o = {{(DataWidth-16){1'b0}}, rd_word_i[15:0]};
      default: load_data_o = '0;
    endcase
  end

  assign merged_o = funct3_i[0] ? {old_word_i[DataWidth-1:16], wdata_i[15:0]}
                                : {old_word_i[DataWidth-1:8], wdata_i[7:0]};

endmodule

// File: rtl/dmem_access_ctrl.sv
// Shares a byte-addressed data memory (async read, sync whole-word write) between the CPU
// load/store unit (c_*) and the loader/DMA (d_*). Round-robin arbitration, one transaction in
// flight, RISC-V load/store semantics; SB/SH become read-modify-write.
//   clk, rst          : clock, synchronous active-high reset
//   c_req_* / d_req_* : request handshake (valid/ready) with we, funct3, addr, wdata
//   c_rsp_* / d_rsp_* : one-cycle response pulse with rdata and err
//   mem_*             : memory address, write enable, write data, read data
module dmem_access_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 17
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  c_req_valid,
  output logic                  c_req_ready,
  input  logic                  c_req_we,
  input  logic [2:0]            c_req_funct3,
  input  logic [ADDR_WIDTH-1:0] c_req_addr,
  input  logic [DATA_WIDTH-1:0] c_req_wdata,
  output logic                  c_rsp_valid,
  output logic [DATA_WIDTH-1:0] c_rsp_rdata,
  output logic                  c_rsp_err,
  input  logic                  d_req_valid,
  output logic                  d_req_ready,
  input  logic                  d_req_we,
  input  logic [2:0]            d_req_funct3,
  input  logic [ADDR_WIDTH-1:0] d_req_addr,
  input  logic [DATA_WIDTH-1:0] d_req_wdata,
  output logic                  d_rsp_valid,
  output logic [DATA_WIDTH-1:0] d_rsp_rdata,
  output logic                  d_rsp_err,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_wd,
  input  logic [DATA_WIDTH-1:0] mem_rd
);

  state_t                state_q, state_d;
  owner_t                owner_q, owner_d;
  owner_t                last_q, last_d;
  logic                  we_q, we_d;
  logic [2:0]            f3_q, f3_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] cap_q, cap_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;

  logic                  gnt_c, gnt_d;
  logic                  sel_we;
  logic [2:0]            sel_f3;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic                  chk_we;
  logic [2:0]            chk_f3;
  logic [ADDR_WIDTH-1:0] chk_addr;
  logic [DATA_WIDTH-1:0] load_data, merged;
  logic                  legal;
  logic                  mem_we_raw;

  // Round-robin: on a tie the port that was not granted last wins.
  always_comb begin
    gnt_c = 1'b0;
    gnt_d = 1'b0;
    if (state_q == StIdle && !rst) begin
      if (c_req_valid && d_req_valid) begin
        if (last_q == OwnD) gnt_c = 1'b1;
        else                gnt_d = 1'b1;
      end else if (c_req_valid) begin
        gnt_c = 1'b1;
      end else if (d_req_valid) begin
        gnt_d = 1'b1;
      end
    end
  end

  assign c_req_ready = gnt_c;
  assign d_req_ready = gnt_d;

  assign sel_we    = gnt_d ? d_req_we     : c_req_we;
  assign sel_f3    = gnt_d ? d_req_funct3 : c_req_funct3;
  assign sel_addr  = gnt_d ? d_req_addr   : c_req_addr;
  assign sel_wdata = gnt_d ? d_req_wdata  : c_req_wdata;

  // Legality is judged on the incoming request in IDLE, on the latched one afterwards.
  assign chk_we   = (state_q == StIdle) ? sel_we   : we_q;
  assign chk_f3   = (state_q == StIdle) ? sel_f3   : f3_q;
  assign chk_addr = (state_q == StIdle) ? sel_addr : addr_q;

  lsu_align #(
    .DataWidth (DATA_WIDTH),
    .AddrWidth (ADDR_WIDTH)
  ) u_align (
    .we_i        (chk_we),
    .funct3_i    (chk_f3),
    .addr_i      (chk_addr),
    .rd_word_i   (mem_rd),
    .old_word_i  (cap_q),
    .wdata_i     (wdata_q),
    .load_data_o (load_data),
    .merged_o    (merged),
    .legal_o     (legal)
  );

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    we_d       = we_q;
    f3_d       = f3_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    cap_d      = cap_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    mem_we_raw = 1'b0;
    mem_addr   = '0;
    mem_wd     = '0;
    unique case (state_q)
      StIdle: begin
        if (gnt_c || gnt_d) begin
          owner_d = gnt_d ? OwnD : OwnC;
          last_d  = owner_d;
          we_d    = sel_we;
          f3_d    = sel_f3;
          addr_d  = sel_addr;
          wdata_d = sel_wdata;
          rdata_d = '0;
          err_d   = !legal;
          state_d = legal ? StAccess : StResp;
        end
      end
      StAccess: begin
        mem_addr = addr_q;
        if (!we_q) begin
          rdata_d = load_data;
          state_d = StResp;
        end else if (f3_q[1]) begin
          mem_we_raw = 1'b1;
          mem_wd     = wdata_q;
          state_d    = StResp;
        end else begin
          cap_d   = mem_rd;
          state_d = StMerge;
        end
      end
      StMerge: begin
        mem_addr   = addr_q;
        mem_we_raw = 1'b1;
        mem_wd     = merged;
        state_d    = StResp;
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Reset must block a write even in the middle of a read-modify-write.
  assign mem_we = mem_we_raw & ~rst;

  assign c_rsp_valid = (state_q == StResp) && (owner_q == OwnC) && !rst;
  assign d_rsp_valid = (state_q == StResp) && (owner_q == OwnD) && !rst;
  assign c_rsp_rdata = c_rsp_valid ? rdata_q : '0;
  assign d_rsp_rdata = d_rsp_valid ? rdata_q : '0;
  assign c_rsp_err   = c_rsp_valid & err_q;
  assign d_rsp_err   = d_rsp_valid & err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      owner_q <= OwnC;
      last_q  <= OwnD;
      we_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      cap_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cap_q   <= cap_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
module tb_dmem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        c_req_valid, c_req_ready, c_req_we;
  logic [2:0]  c_req_funct3;
  logic [16:0] c_req_addr;
  logic [31:0] c_req_wdata;
  logic        c_rsp_valid, c_rsp_err;
  logic [31:0] c_rsp_rdata;
  logic        d_req_valid, d_req_ready, d_req_we;
  logic [2:0]  d_req_funct3;
  logic [16:0] d_req_addr;
  logic [31:0] d_req_wdata;
  logic        d_rsp_valid, d_rsp_err;
  logic [31:0] d_rsp_rdata;
  logic [16:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wd, mem_rd;

  int vectors = 0;
  int miscompares = 0;
  int hold_errs = 0;
  logic [31:0] last_wd;

  always #5 clk = ~clk;

  dmem_access_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .c_req_valid  (c_req_valid),
    .c_req_ready  (c_req_ready),
    .c_req_we     (c_req_we),
    .c_req_funct3 (c_req_funct3),
    .c_req_addr   (c_req_addr),
    .c_req_wdata  (c_req_wdata),
    .c_rsp_valid  (c_rsp_valid),
    .c_rsp_rdata  (c_rsp_rdata),
    .c_rsp_err    (c_rsp_err),
    .d_req_valid  (d_req_valid),
    .d_req_ready  (d_req_ready),
    .d_req_we     (d_req_we),
    .d_req_funct3 (d_req_funct3),
    .d_req_addr   (d_req_addr),
    .d_req_wdata  (d_req_wdata),
    .d_rsp_valid  (d_rsp_valid),
    .d_rsp_rdata  (d_rsp_rdata),
    .d_rsp_err    (d_rsp_err),
    .mem_addr     (mem_addr),
    .mem_we       (mem_we),
    .mem_wd       (mem_wd),
    .mem_rd       (mem_rd)
  );

  // Byte-addressed memory: a word access covers addr..addr+3 (little-endian, wrapping).
  logic [7:0] mem [0:131071];

  always_comb begin
    mem_rd = {mem[mem_addr + 17'd3], mem[mem_addr + 17'd2], mem[mem_addr + 17'd1], mem[mem_addr]};
  end

  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr]         <= mem_wd[7:0];
      mem[mem_addr + 17'd1] <= mem_wd[15:8];
      mem[mem_addr + 17'd2] <= mem_wd[23:16];
      mem[mem_addr + 17'd3] <= mem_wd[31:24];
    end
  end

  // A pending request (valid && !ready) must be held stable until accepted.
  logic        c_pend = 1'b0, d_pend = 1'b0;
  logic [52:0] c_snap, d_snap;
  always @(posedge clk) begin
    if (c_pend && !(c_req_valid && {c_req_we, c_req_funct3, c_req_addr, c_req_wdata} == c_snap)) begin
      hold_errs++;
      $error("FAIL c_hold: request changed while pending");
    end
    if (d_pend && !(d_req_valid && {d_req_we, d_req_funct3, d_req_addr, d_req_wdata} == d_snap)) begin
      hold_errs++;
      $error("FAIL d_hold: request changed while pending");
    end
    c_pend = c_req_valid && !c_req_ready;
    d_pend = d_req_valid && !d_req_ready;
    c_snap = {c_req_we, c_req_funct3, c_req_addr, c_req_wdata};
    d_snap = {d_req_we, d_req_funct3, d_req_addr, d_req_wdata};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one request (called at a negedge) and check acceptance, latency, response,
  // number of write cycles and silence on the other port.
  task automatic do_req(input string tag, input logic is_d, input logic we, input logic [2:0] f3,
                        input logic [16:0] addr, input logic [31:0] wdata, input int exp_lat,
                        input logic [31:0] exp_rdata, input logic exp_err, input int exp_wes);
    int waited, lat, wes;
    logic rdy, other;
    logic [31:0] rd;
    logic er;
    if (is_d) begin
      d_req_valid = 1'b1; d_req_we = we; d_req_funct3 = f3; d_req_addr = addr; d_req_wdata = wdata;
    end else begin
      c_req_valid = 1'b1; c_req_we = we; c_req_funct3 = f3; c_req_addr = addr; c_req_wdata = wdata;
    end
    #1;
    waited = 0;
    rdy = is_d ? d_req_ready : c_req_ready;
    while (!rdy && waited < 8) begin
      @(negedge clk); #1;
      waited++;
      rdy = is_d ? d_req_ready : c_req_ready;
    end
    chk({tag, ".accept"}, {31'd0, rdy}, 32'd1);
    @(posedge clk); #1;
    if (is_d) d_req_valid = 1'b0;
    else      c_req_valid = 1'b0;
    lat = 0; wes = 0; other = 1'b0; rd = '0; er = 1'b0;
    for (int n = 1; n <= 6; n++) begin
      @(negedge clk);
      if (mem_we) begin
        wes++;
        last_wd = mem_wd;
      end
      if (is_d ? c_rsp_valid : d_rsp_valid) other = 1'b1;
      if (is_d ? d_rsp_valid : c_rsp_valid) begin
        lat = n;
        rd  = is_d ? d_rsp_rdata : c_rsp_rdata;
        er  = is_d ? d_rsp_err : c_rsp_err;
        break;
      end
    end
    chk({tag, ".latency"}, lat, exp_lat);
    chk({tag, ".rdata"}, rd, exp_rdata);
    chk({tag, ".err"}, {31'd0, er}, {31'd0, exp_err});
    chk({tag, ".we_cycles"}, wes, exp_wes);
    chk({tag, ".other_rsp"}, {31'd0, other}, 32'd0);
  endtask

  initial begin
    // Both ports request LW while reset is held: nothing may be granted yet.
    rst = 1'b1;
    c_req_valid = 1'b1; c_req_we = 1'b0; c_req_funct3 = 3'b010; c_req_addr = 17'h0;
    c_req_wdata = '0;
    d_req_valid = 1'b1; d_req_we = 1'b0; d_req_funct3 = 3'b010; d_req_addr = 17'h4;
    d_req_wdata = '0;
    last_wd = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst.c_ready", {31'd0, c_req_ready}, 32'd0);
    chk("rst.d_ready", {31'd0, d_req_ready}, 32'd0);
    chk("rst.rsp_valid", {30'd0, c_rsp_valid, d_rsp_valid}, 32'd0);
    chk("rst.rsp_err", {30'd0, c_rsp_err, d_rsp_err}, 32'd0);
    chk("rst.c_rdata", c_rsp_rdata, 32'd0);
    chk("rst.d_rdata", d_rsp_rdata, 32'd0);
    chk("rst.mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst.mem_addr", {15'd0, mem_addr}, 32'd0);
    chk("rst.mem_wd", mem_wd, 32'd0);

    // Tie from reset: CPU first, DMA right after CPU's response, next tie back to CPU.
    rst = 1'b0;
    #1;
    chk("tie1.c_ready", {31'd0, c_req_ready}, 32'd1);
    chk("tie1.d_ready", {31'd0, d_req_ready}, 32'd0);
    @(posedge clk); #1;
    c_req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("tie1.c_rsp", {30'd0, c_rsp_valid, d_rsp_valid}, 32'd2);
    @(negedge clk); #1;
    chk("tie1.d_ready", {31'd0, d_req_ready}, 32'd1);
    @(posedge clk); #1;
    d_req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("tie1.d_rsp", {30'd0, c_rsp_valid, d_rsp_valid}, 32'd1);
    c_req_valid = 1'b1;
    d_req_valid = 1'b1;
    @(negedge clk); #1;
    chk("tie2.grant", {30'd0, c_req_ready, d_req_ready}, 32'd2);
    @(posedge clk); #1;
    c_req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("tie2.c_rsp", {30'd0, c_rsp_valid, d_rsp_valid}, 32'd2);
    @(negedge clk); #1;
    chk("tie2.d_ready", {31'd0, d_req_ready}, 32'd1);
    @(posedge clk); #1;
    d_req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("tie2.d_rsp", {30'd0, c_rsp_valid, d_rsp_valid}, 32'd1);

    // SW then LW.
    do_req("sw100", 1'b0, 1'b1, 3'b010, 17'h100, 32'hDEADBEEF, 2, 32'h0, 1'b0, 1);
    chk("sw100.wd", last_wd, 32'hDEADBEEF);
    do_req("lw100", 1'b0, 1'b0, 3'b010, 17'h100, 32'h0, 2, 32'hDEADBEEF, 1'b0, 0);

    // Word at 0x101 becomes 0x11223344, then SB 0xA5 over its low byte.
    do_req("sw100b", 1'b0, 1'b1, 3'b010, 17'h100, 32'h22334400, 2, 32'h0, 1'b0, 1);
    do_req("sw104", 1'b0, 1'b1, 3'b010, 17'h104, 32'h00000011, 2, 32'h0, 1'b0, 1);
    do_req("lbu101a", 1'b0, 1'b0, 3'b100, 17'h101, 32'h0, 2, 32'h00000044, 1'b0, 0);
    do_req("sb101", 1'b0, 1'b1, 3'b000, 17'h101, 32'h000000A5, 3, 32'h0, 1'b0, 1);
    chk("sb101.wd", last_wd, 32'h112233A5);
    do_req("lbu101", 1'b0, 1'b0, 3'b100, 17'h101, 32'h0, 2, 32'h000000A5, 1'b0, 0);
    do_req("lb101", 1'b0, 1'b0, 3'b000, 17'h101, 32'h0, 2, 32'hFFFFFFA5, 1'b0, 0);
    do_req("lw100c", 1'b0, 1'b0, 3'b010, 17'h100, 32'h0, 2, 32'h2233A500, 1'b0, 0);

    // Illegal accesses: error after one cycle, no memory write.
    do_req("lh103", 1'b0, 1'b0, 3'b001, 17'h103, 32'h0, 1, 32'h0, 1'b1, 0);
    do_req("ld011", 1'b0, 1'b0, 3'b011, 17'h100, 32'h0, 1, 32'h0, 1'b1, 0);
    do_req("sw102", 1'b0, 1'b1, 3'b010, 17'h102, 32'h0, 1, 32'h0, 1'b1, 0);
    do_req("st100", 1'b0, 1'b1, 3'b100, 17'h100, 32'h0, 1, 32'h0, 1'b1, 0);
    do_req("sbtop", 1'b0, 1'b1, 3'b000, 17'h1FFFE, 32'h0, 1, 32'h0, 1'b1, 0);

    // Top of memory: last aligned word is legal, byte loads there too.
    do_req("swtop", 1'b1, 1'b1, 3'b010, 17'h1FFFC, 32'hCAFEF00D, 2, 32'h0, 1'b0, 1);
    do_req("lbutop", 1'b1, 1'b0, 3'b100, 17'h1FFFF, 32'h0, 2, 32'h000000CA, 1'b0, 0);
    do_req("shtop", 1'b1, 1'b1, 3'b001, 17'h1FFFC, 32'h1234, 3, 32'h0, 1'b0, 1);
    chk("shtop.wd", last_wd, 32'hCAFE1234);

    // DMA halfword store/loads; CPU response stays quiet (checked inside do_req).
    do_req("sw200", 1'b1, 1'b1, 3'b010, 17'h200, 32'h0, 2, 32'h0, 1'b0, 1);
    do_req("sh200", 1'b1, 1'b1, 3'b001, 17'h200, 32'h00008001, 3, 32'h0, 1'b0, 1);
    chk("sh200.wd", last_wd, 32'h00008001);
    do_req("lh200", 1'b1, 1'b0, 3'b001, 17'h200, 32'h0, 2, 32'hFFFF8001, 1'b0, 0);
    do_req("lhu200", 1'b1, 1'b0, 3'b101, 17'h200, 32'h0, 2, 32'h00008001, 1'b0, 0);

    // Reset in the MERGE cycle of an SB: write suppressed, no response, memory intact.
    do_req("sw300", 1'b0, 1'b1, 3'b010, 17'h300, 32'h01020304, 2, 32'h0, 1'b0, 1);
    c_req_valid = 1'b1; c_req_we = 1'b1; c_req_funct3 = 3'b000; c_req_addr = 17'h300;
    c_req_wdata = 32'h000000FF;
    @(negedge clk); #1;
    chk("rstm.accept", {31'd0, c_req_ready}, 32'd1);
    @(posedge clk); #1;
    c_req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rstm.merge_we", {31'd0, mem_we}, 32'd1);
    chk("rstm.merge_wd", mem_wd, 32'h010203FF);
    rst = 1'b1;
    #1;
    chk("rstm.we_forced", {31'd0, mem_we}, 32'd0);
    @(posedge clk); #1;
    chk("rstm.rsp_in_rst", {30'd0, c_rsp_valid, d_rsp_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rstm.rsp_after", {30'd0, c_rsp_valid, d_rsp_valid}, 32'd0);
    do_req("lw300", 1'b0, 1'b0, 3'b010, 17'h300, 32'h0, 2, 32'h01020304, 1'b0, 0);

    miscompares += hold_errs;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
